// File: rtl/axi_rd_slave.sv
// AXI4 read-only slave backed by an internal 64-bit word memory with a backdoor preload port.
// Define AXI_RD_ERR_EN to return SLVERR for out-of-range beats and ARBURST=11.
module axi_rd_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ARID,
    input  logic [63:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic [2:0]  ARSIZE,
    input  logic [1:0]  ARBURST,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [3:0]  RID,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic        bd_we,
    input  logic [63:0] bd_addr,
    input  logic [63:0] bd_wdata
);

    localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
`ifdef AXI_RD_ERR_EN
    localparam logic [63:0] AddrLimit = ADDR_BASE + 64'(MEM_WORDS) * 64'd8;
`endif

    typedef enum logic [1:0] {StIdle, StLat, StBurst} state_e;

    state_e      state_q, state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [3:0]  rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [63:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  id_q, id_d;
    logic        load_beat;
    logic        beat_err;

    logic [63:0] mem_q [MEM_WORDS];

    function automatic logic [IdxW-1:0] word_idx(input logic [63:0] a);
        return IdxW'((a - ADDR_BASE) >> 3);
    endfunction

    // No reset on storage so contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem_q[word_idx(bd_addr)] <= bd_wdata;
        end
    end

    always_comb begin
`ifdef AXI_RD_ERR_EN
        beat_err = (addr_d < ADDR_BASE) || (addr_d >= AddrLimit) || (burst_d == 2'b11);
`else
        beat_err = 1'b0;
`endif
    end

    // addr_d/burst_d always describe the beat being loaded into the output register.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        load_beat = 1'b0;

        unique case (state_q)
            StIdle: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    id_d      = ARID;
                    addr_d    = ARADDR;
                    len_d     = ARLEN;
                    size_d    = ARSIZE;
                    burst_d   = ARBURST;
                    beat_d    = 8'd0;
                    cnt_d     = 4'(RD_LAT - 1);
                    arready_d = 1'b0;
                    if (RD_LAT == 1) begin
                        state_d   = StBurst;
                        load_beat = 1'b1;
                    end else begin
                        state_d = StLat;
                    end
                end
            end
            StLat: begin
                cnt_d = cnt_q - 4'd1;
                // Word fetched on the edge the counter reaches zero, so RVALID follows directly.
                if (cnt_q == 4'd1) begin
                    state_d   = StBurst;
                    load_beat = 1'b1;
                end
            end
            StBurst: begin
                if (RREADY) begin
                    if (beat_q == len_q) begin
                        state_d   = StIdle;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        beat_d    = beat_q + 8'd1;
                        addr_d    = (burst_q == 2'b00) ? addr_q : addr_q + (64'd1 << size_q);
                        load_beat = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_beat) begin
            rvalid_d = 1'b1;
            rid_d    = id_d;
            rlast_d  = (beat_d == len_d);
            rresp_d  = beat_err ? 2'b10 : 2'b00;
            rdata_d  = beat_err ? 64'd0 : mem_q[word_idx(addr_d)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rresp_q   <= 2'b00;
            rdata_q   <= 64'd0;
            cnt_q     <= 4'd0;
            addr_q    <= 64'd0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            id_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: table of bursts plus reset and backdoor corner sequences.
module tb_axi_rd_slave;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        bd_we;
    logic [63:0] bd_addr;
    logic [63:0] bd_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [7:0]       rpat;
        logic [3:0][63:0] data;
        logic [1:0]       resp;
    } vec_t;

    vec_t vecs[8];

    axi_rd_slave dut (
        .clk      (clk),
        .rst      (rst),
        .ARID     (ARID),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARSIZE   (ARSIZE),
        .ARBURST  (ARBURST),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RID      (RID),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RLAST    (RLAST),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] wval(input int i);
        return (i == 0) ? 64'h1111 : (64'hD00D_0000_0000_0000 | 64'(i));
    endfunction

    function automatic vec_t mk(input logic [63:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] id, input logic [7:0] rpat,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [63:0] d2, input logic [63:0] d3,
                                input logic [1:0] resp);
        vec_t v;
        v.addr    = addr;
        v.len     = len;
        v.size    = size;
        v.burst   = burst;
        v.id      = id;
        v.rpat    = rpat;
        v.data[0] = d0;
        v.data[1] = d1;
        v.data[2] = d2;
        v.data[3] = d3;
        v.resp    = resp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int idx, input logic [63:0] val);
        bd_we    = 1'b1;
        bd_addr  = BASE + 64'(idx) * 64'd8;
        bd_wdata = val;
        tick();
        bd_we = 1'b0;
    endtask

    // Issues one read burst and checks every presented beat against the vector.
    task automatic run_vec(input int n, input vec_t v);
        int beats = 0;
        int cyc   = 0;
        int pidx  = 0;
        ARVALID = 1'b1;
        ARID    = v.id;
        ARADDR  = v.addr;
        ARLEN   = v.len;
        ARSIZE  = v.size;
        ARBURST = v.burst;
        RREADY  = v.rpat[0];
        while (!ARREADY && cyc < 20) begin
            tick();
            cyc++;
        end
        chk($sformatf("v%0d arready", n), 64'(ARREADY), 64'd1);
        tick();
        ARVALID = 1'b0;
        chk($sformatf("v%0d first rvalid", n), 64'(RVALID), 64'd1);
        cyc = 0;
        while (beats <= int'(v.len) && cyc < 64) begin
            if (RVALID) begin
                chk($sformatf("v%0d b%0d rdata", n, beats), RDATA, v.data[beats[1:0]]);
                chk($sformatf("v%0d b%0d rid", n, beats), 64'(RID), 64'(v.id));
                chk($sformatf("v%0d b%0d rresp", n, beats), 64'(RRESP), 64'(v.resp));
                chk($sformatf("v%0d b%0d rlast", n, beats), 64'(RLAST),
                    64'(beats == int'(v.len)));
                if (RREADY) beats++;
            end else begin
                chk($sformatf("v%0d rvalid mid-burst", n), 64'(RVALID), 64'd1);
            end
            tick();
            cyc++;
            pidx++;
            RREADY = v.rpat[pidx[2:0]];
        end
        chk($sformatf("v%0d beat count", n), 64'(beats), 64'(v.len) + 64'd1);
        chk($sformatf("v%0d rvalid after", n), 64'(RVALID), 64'd0);
        chk($sformatf("v%0d arready after", n), 64'(ARREADY), 64'd1);
        RREADY = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ARID     = '0;
        ARADDR   = '0;
        ARLEN    = '0;
        ARSIZE   = '0;
        ARBURST  = '0;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = '0;

        vecs[0] = mk(BASE, 8'd0, 3'd3, 2'b01, 4'd1, 8'hFF,
                     wval(0), 64'd0, 64'd0, 64'd0, 2'b00);
        vecs[1] = mk(BASE, 8'd3, 3'd3, 2'b01, 4'd5, 8'hFF,
                     wval(0), wval(1), wval(2), wval(3), 2'b00);
        vecs[2] = mk(BASE, 8'd3, 3'd3, 2'b01, 4'd5, 8'b1001_1001,
                     wval(0), wval(1), wval(2), wval(3), 2'b00);
        vecs[3] = mk(BASE + 64'd56, 8'd2, 3'd3, 2'b00, 4'd2, 8'hFF,
                     wval(7), wval(7), wval(7), 64'd0, 2'b00);
        vecs[4] = mk(BASE + 64'd8, 8'd3, 3'd2, 2'b01, 4'd9, 8'b1101_0110,
                     wval(1), wval(1), wval(2), wval(2), 2'b00);
        vecs[5] = mk(BASE + 64'd16, 8'd1, 3'd3, 2'b10, 4'd3, 8'hFF,
                     wval(2), wval(3), 64'd0, 64'd0, 2'b00);
`ifdef AXI_RD_ERR_EN
        vecs[6] = mk(BASE - 64'd8, 8'd1, 3'd3, 2'b00, 4'd6, 8'hFF,
                     64'd0, 64'd0, 64'd0, 64'd0, 2'b10);
        vecs[7] = mk(BASE + 64'd32, 8'd1, 3'd3, 2'b11, 4'd7, 8'hFF,
                     64'd0, 64'd0, 64'd0, 64'd0, 2'b10);
`else
        vecs[6] = mk(BASE - 64'd8, 8'd1, 3'd3, 2'b00, 4'd6, 8'hFF,
                     wval(1023), wval(1023), 64'd0, 64'd0, 2'b00);
        vecs[7] = mk(BASE + 64'd32, 8'd1, 3'd3, 2'b11, 4'd7, 8'hFF,
                     wval(4), wval(5), 64'd0, 64'd0, 2'b00);
`endif

        tick();
        tick();
        chk("reset arready", 64'(ARREADY), 64'd0);
        chk("reset rvalid", 64'(RVALID), 64'd0);
        chk("reset rlast", 64'(RLAST), 64'd0);
        chk("reset rid", 64'(RID), 64'd0);
        chk("reset rresp", 64'(RRESP), 64'd0);
        chk("reset rdata", RDATA, 64'd0);
        rst = 1'b0;
        tick();
        chk("arready after reset", 64'(ARREADY), 64'd1);

        for (int i = 0; i < 16; i++) bd_write(i, wval(i));
        bd_write(1023, wval(1023));

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while the third beat of a 4-beat burst is presented.
        ARVALID = 1'b1;
        ARID    = 4'd5;
        ARADDR  = BASE;
        ARLEN   = 8'd3;
        ARSIZE  = 3'd3;
        ARBURST = 2'b01;
        RREADY  = 1'b1;
        tick();
        ARVALID = 1'b0;
        tick();
        tick();
        chk("pre-reset beat2 rdata", RDATA, wval(2));
        rst = 1'b1;
        tick();
        chk("mid-burst reset rvalid", 64'(RVALID), 64'd0);
        chk("mid-burst reset rlast", 64'(RLAST), 64'd0);
        chk("mid-burst reset arready", 64'(ARREADY), 64'd0);
        rst    = 1'b0;
        RREADY = 1'b0;
        tick();
        chk("arready after mid-burst reset", 64'(ARREADY), 64'd1);
        chk("rvalid after mid-burst reset", 64'(RVALID), 64'd0);
        run_vec(8, vecs[1]);

        // Backdoor write to the word fetched on the AR handshake edge: old data wins.
        ARVALID  = 1'b1;
        ARID     = 4'd4;
        ARADDR   = BASE + 64'd72;
        ARLEN    = 8'd0;
        ARSIZE   = 3'd3;
        ARBURST  = 2'b01;
        RREADY   = 1'b1;
        bd_we    = 1'b1;
        bd_addr  = BASE + 64'd72;
        bd_wdata = 64'hFEED_FACE_0000_0009;
        tick();
        ARVALID = 1'b0;
        bd_we   = 1'b0;
        chk("bd collision rvalid", 64'(RVALID), 64'd1);
        chk("bd collision old data", RDATA, wval(9));
        chk("bd collision rlast", 64'(RLAST), 64'd1);
        tick();
        RREADY = 1'b0;
        run_vec(9, mk(BASE + 64'd72, 8'd0, 3'd3, 2'b01, 4'd4, 8'hFF,
                      64'hFEED_FACE_0000_0009, 64'd0, 64'd0, 64'd0, 2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
